i2c_rtc_sequencer: RTL and testbench

I2C_RTC_SEQUENCER -- requirements
Module: i2c_rtc_sequencer

---
 rtl/i2c_rtc_sequencer_pkg.sv | 35 +++
 rtl/i2c_rtc_sequencer_poll_timer.sv | 23 ++
 rtl/i2c_rtc_sequencer.sv | 153 +++++++++++++++
 tb/tb_i2c_rtc_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_rtc_sequencer_pkg.sv
// Shared types and constants for the RTC polling/set sequencer.
package i2c_rtc_sequencer_pkg;

  // Sequencer states. These are kept as plain constants so existing tools and
  // waveform scripts keep seeing the same 3-bit encodings.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE        = 3'd0;
  localparam state_t ST_ISSUE       = 3'd1;
  localparam state_t ST_WAIT_ACCEPT = 3'd2;
  localparam state_t ST_WAIT_DONE   = 3'd3;
  localparam state_t ST_DONE        = 3'd4;
  localparam state_t ST_BACKOFF     = 3'd5;
  localparam state_t ST_FAULT       = 3'd6;

  // Which kind of I2C job is currently in flight.
  typedef enum logic {
    JOB_POLL = 1'b0,
    JOB_SET  = 1'b1
  } job_t;

  // RTC register pointer of the seconds register. The time block starts here.
  localparam logic [7:0] REG_PTR = 8'h00;

  // The seconds register carries the oscillator-halt flag in bit 7 and the
  // hours register carries the 12/24 mode bits in 7:6. Neither is time data.
  localparam logic [7:0] SS_MASK = 8'h7F;
  localparam logic [7:0] MM_MASK = 8'hFF;
  localparam logic [7:0] HH_MASK = 8'h3F;

  // Strip the non-time control bits from a raw {hh,mm,ss} read.
  function automatic logic [23:0] mask_time(input logic [23:0] raw);
    return {raw[23:16] & HH_MASK, raw[15:8] & MM_MASK, raw[7:0] & SS_MASK};
  endfunction

endpackage

// File: rtl/i2c_rtc_sequencer_poll_timer.sv
// Free-running period counter; tick is high for the one cycle before wrap.
module poll_timer #(
  parameter int PollTicks = 2_400_000
) (
  input  logic clock,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (PollTicks > 1) ? $clog2(PollTicks) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(PollTicks - 1));

  // Count 0..PollTicks-1 and wrap.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/i2c_rtc_sequencer.sv
// Periodically reads {hh,mm,ss} from an I2C RTC and writes it on request,
// driving a byte-oriented I2C master with retry/backoff and a sticky fault.
module i2c_rtc_sequencer
  import i2c_rtc_sequencer_pkg::*;
#(
  parameter int         ClockFrequency = 24_000_000,
  parameter int         PollPeriodMs   = 100,
  parameter logic [6:0] DeviceAddress  = 7'h68,
  parameter int         MaxRetries     = 3,
  parameter int         RetryDelay     = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        setTimeValid,
  output logic        setTimeReady,
  input  logic [23:0] setTimeData,
  output logic        timeValid,
  output logic [23:0] timeData,
  output logic        busy,
  output logic        fault,
  output logic        i2cStart,
  output logic [6:0]  i2cAddress,
  output logic [2:0]  i2cNrOfBytesToSend,
  output logic [31:0] i2cBytesToSend,
  output logic [2:0]  i2cNrOfBytesToRead,
  input  logic [23:0] i2cBytesToRead,
  input  logic        i2cReady,
  input  logic        i2cClockStretchTimeoutReached
);

  localparam int PollTicks = ClockFrequency / 1000 * PollPeriodMs;
  localparam int RW        = $clog2(MaxRetries + 1);
  localparam int BW        = $clog2(RetryDelay + 1);

  logic [1:0]    rst_sync;
  logic          rst_n;
  logic          tick;
  state_t        state;
  job_t          job;
  logic [23:0]   set_data;
  logic          poll_pending;
  logic          failed;
  logic [RW-1:0] retry_cnt;
  logic [RW-1:0] retry_nxt;
  logic [BW-1:0] bo_cnt;
  logic          take_set;
  logic          take_poll;

  // Assert asynchronously, release two clocks after reset goes high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  poll_timer #(.PollTicks(PollTicks)) u_poll_timer (
    .clock (clock),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign setTimeReady = rst_n && (state == ST_IDLE) && enable && !fault;
  assign take_set     = setTimeValid && setTimeReady;
  assign take_poll    = (state == ST_IDLE) && !take_set && poll_pending && enable;
  assign busy         = (state != ST_IDLE) && (state != ST_FAULT);
  assign fault        = (state == ST_FAULT);
  assign retry_nxt    = retry_cnt + 1'b1;

  // Job descriptor seen by the I2C master; byte 0 is the register pointer.
  assign i2cAddress         = DeviceAddress;
  assign i2cNrOfBytesToSend = (job == JOB_SET) ? 3'd4 : 3'd1;
  assign i2cBytesToSend     = (job == JOB_SET) ? {set_data, REG_PTR} : {24'h0, REG_PTR};
  assign i2cNrOfBytesToRead = (job == JOB_SET) ? 3'd0 : 3'd3;

  // Sticky poll request; dropped whenever the block is disabled.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) poll_pending <= 1'b0;
    else        poll_pending <= enable && ((poll_pending && !take_poll) || tick);
  end

  // Job sequencing: issue, handshake with the master, retry or fault.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      job       <= JOB_POLL;
      set_data  <= '0;
      failed    <= 1'b0;
      retry_cnt <= '0;
      bo_cnt    <= '0;
      i2cStart  <= 1'b0;
      timeValid <= 1'b0;
      timeData  <= '0;
    end else begin
      timeValid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take_set) begin
            job      <= JOB_SET;
            set_data <= setTimeData;
            state    <= ST_ISSUE;
          end else if (take_poll) begin
            job   <= JOB_POLL;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          failed <= 1'b0;
          if (i2cReady) begin
            i2cStart <= 1'b1;
            state    <= ST_WAIT_ACCEPT;
          end
        end
        ST_WAIT_ACCEPT: begin
          if (!i2cReady) begin
            i2cStart <= 1'b0;
            state    <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          failed <= failed || i2cClockStretchTimeoutReached;
          if (i2cReady) state <= ST_DONE;
        end
        ST_DONE: begin
          if (!failed) begin
            retry_cnt <= '0;
            if (job == JOB_POLL) begin
              timeData  <= mask_time(i2cBytesToRead);
              timeValid <= 1'b1;
            end
            state <= ST_IDLE;
          end else begin
            retry_cnt <= retry_nxt;
            bo_cnt    <= '0;
            state     <= (retry_nxt >= RW'(MaxRetries)) ? ST_FAULT : ST_BACKOFF;
          end
        end
        ST_BACKOFF: begin
          if (bo_cnt == BW'(RetryDelay - 1)) state  <= ST_ISSUE;
          else                               bo_cnt <= bo_cnt + 1'b1;
        end
        ST_FAULT: begin
          if (!enable) begin
            retry_cnt <= '0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_rtc_sequencer.sv
// Self-checking bench: behavioural I2C master/RTC responder plus scenario tasks.
module tb_i2c_rtc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        setTimeValid = 1'b0;
  logic [23:0] setTimeData = '0;
  logic        setTimeReady, timeValid, busy, fault, i2cStart;
  logic [23:0] timeData;
  logic [6:0]  i2cAddress;
  logic [2:0]  nsend, nread;
  logic [31:0] bsend;
  logic [23:0] i2cBytesToRead = '0;
  logic        i2cReady;
  logic        stretch = 1'b0;
  logic        slave_rdy = 1'b1;
  logic        hold_low = 1'b0;

  assign i2cReady = slave_rdy & ~hold_low;

  int cmp = 0;
  int mis = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int fail_cnt = 0;
  logic [23:0] rsp = '0;

  int          tx_count = 0;
  int          tx_cyc[$];
  logic [31:0] tx_bytes[$];
  logic [2:0]  tx_ns[$];
  logic [2:0]  tx_nr[$];
  logic [23:0] tv_q[$];
  int          tv_tx[$];

  i2c_rtc_sequencer #(
    .ClockFrequency(24_000), .PollPeriodMs(1), .DeviceAddress(7'h68),
    .MaxRetries(3), .RetryDelay(1024)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .setTimeValid(setTimeValid), .setTimeReady(setTimeReady), .setTimeData(setTimeData),
    .timeValid(timeValid), .timeData(timeData), .busy(busy), .fault(fault),
    .i2cStart(i2cStart), .i2cAddress(i2cAddress), .i2cNrOfBytesToSend(nsend),
    .i2cBytesToSend(bsend), .i2cNrOfBytesToRead(nread), .i2cBytesToRead(i2cBytesToRead),
    .i2cReady(i2cReady), .i2cClockStretchTimeoutReached(stretch)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Reference view of a time read: control bits in ss[7] and hh[7:6] are not time.
  function automatic logic [23:0] expect_time(input logic [23:0] raw);
    return {2'b00, raw[21:16], raw[15:8], 1'b0, raw[6:0]};
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // I2C master + RTC responder: accepts a start, is busy 4 cycles, optionally
  // reports a clock-stretch timeout, then returns rsp and goes ready.
  initial begin : slave
    bit fail_now;
    forever begin
      @(negedge clock);
      if (i2cStart && i2cReady) begin
        tx_count++;
        tx_cyc.push_back(cyc);
        tx_bytes.push_back(bsend);
        tx_ns.push_back(nsend);
        tx_nr.push_back(nread);
        fail_now = (fail_cnt > 0);
        if (fail_now) fail_cnt--;
        slave_rdy = 1'b0;
        repeat (4) @(negedge clock);
        if (fail_now) begin
          stretch = 1'b1;
          @(negedge clock);
          stretch = 1'b0;
        end
        i2cBytesToRead = rsp;
        slave_rdy = 1'b1;
      end
    end
  end

  initial begin : tv_mon
    forever begin
      @(negedge clock);
      if (timeValid) begin
        tv_q.push_back(timeData);
        tv_tx.push_back(tx_count);
      end
    end
  end

  task automatic do_reset(input bit en, input bit hold);
    @(negedge clock);
    reset = 1'b0; enable = en; setTimeValid = 1'b0; hold_low = hold; fail_cnt = 0;
    repeat (8) @(negedge clock);
    tx_count = 0;
    tx_cyc.delete(); tx_bytes.delete(); tx_ns.delete(); tx_nr.delete();
    tv_q.delete(); tv_tx.delete();
    reset = 1'b1;
    rel_cyc = cyc;
  endtask

  // Present a set request at a negedge and hold it until accepted.
  task automatic send_set(input logic [23:0] d, output bit ok);
    bit acc;
    ok = 1'b0;
    setTimeData = d;
    setTimeValid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      acc = setTimeReady;
      @(negedge clock);
      if (acc) begin ok = 1'b1; break; end
    end
    setTimeValid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clock);
    cmp++; if ({busy, fault, i2cStart, timeValid, setTimeReady} !== 5'b0) begin
      mis++; $display("FAIL reset_outputs: got %b want 00000", {busy, fault, i2cStart, timeValid, setTimeReady}); end
    cmp++; if (timeData !== 24'h0) begin mis++; $display("FAIL reset_timeData: got %h want 000000", timeData); end
    reset = 1'b1;
    repeat (4) @(negedge clock);
    cmp++; if (setTimeReady !== 1'b1) begin mis++; $display("FAIL ready_after_reset: got %b want 1", setTimeReady); end
    cmp++; if (i2cAddress !== 7'h68) begin mis++; $display("FAIL address: got %h want 68", i2cAddress); end
    cmp++; if (busy !== 1'b0) begin mis++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_poll;
    int d;
    rsp = 24'h12_34_D6;
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 200 && tv_q.size() == 0; i++) @(negedge clock);
    cmp++; if (tv_q.size() < 1) begin mis++; $display("FAIL poll_timeout: got 0 pulses want 1"); end
    else begin
      d = tx_cyc[0] - rel_cyc;
      cmp++; if (d < 24 || d > 30) begin mis++; $display("FAIL poll_latency: got %0d cycles want 24..30", d); end
      cmp++; if (tv_q[0] !== 24'h12_34_56) begin mis++; $display("FAIL poll_data: got %h want 123456", tv_q[0]); end
      cmp++; if ({tx_ns[0], tx_bytes[0], tx_nr[0]} !== {3'd1, 32'h0, 3'd3}) begin
        mis++; $display("FAIL poll_desc: got %0d/%h/%0d want 1/00000000/3", tx_ns[0], tx_bytes[0], tx_nr[0]); end
      cmp++; if (tv_tx[0] !== 1) begin mis++; $display("FAIL poll_once: got %0d transactions want 1", tv_tx[0]); end
    end
  endtask

  task automatic test_set_vs_poll;
    bit ok;
    rsp = 24'h00_00_00;
    do_reset(1'b1, 1'b0);
    repeat (25) @(negedge clock);
    send_set(24'h23_59_00, ok);
    cmp++; if (!ok) begin mis++; $display("FAIL set_accept: got 0 want 1"); end
    for (int i = 0; i < 200 && tx_count < 2; i++) @(negedge clock);
    cmp++; if (tx_count < 2) begin mis++; $display("FAIL set_poll_count: got %0d want 2", tx_count); end
    else begin
      cmp++; if ({tx_ns[0], tx_bytes[0], tx_nr[0]} !== {3'd4, 32'h23_59_00_00, 3'd0}) begin
        mis++; $display("FAIL set_first: got %0d/%h/%0d want 4/23590000/0", tx_ns[0], tx_bytes[0], tx_nr[0]); end
      cmp++; if ({tx_ns[1], tx_nr[1]} !== {3'd1, 3'd3}) begin
        mis++; $display("FAIL poll_second: got %0d/%0d want 1/3", tx_ns[1], tx_nr[1]); end
    end
  endtask

  task automatic test_retry_fault;
    int g;
    do_reset(1'b1, 1'b0);
    fail_cnt = 3;
    for (int i = 0; i < 4000 && !fault; i++) @(negedge clock);
    cmp++; if (fault !== 1'b1) begin mis++; $display("FAIL fault_set: got %b want 1", fault); end
    cmp++; if (tx_count !== 3) begin mis++; $display("FAIL fault_attempts: got %0d want 3", tx_count); end
    else begin
      for (int k = 1; k < 3; k++) begin
        g = tx_cyc[k] - tx_cyc[k-1];
        cmp++; if (g < 1029 || g > 1036) begin mis++; $display("FAIL backoff_gap%0d: got %0d want 1029..1036", k, g); end
      end
    end
    cmp++; if ({busy, setTimeReady} !== 2'b00) begin mis++; $display("FAIL fault_idle: got %b want 00", {busy, setTimeReady}); end
    repeat (100) @(negedge clock);
    cmp++; if (tx_count !== 3) begin mis++; $display("FAIL fault_quiet: got %0d want 3", tx_count); end
    enable = 1'b0;
    repeat (2) @(negedge clock);
    cmp++; if ({fault, busy} !== 2'b00) begin mis++; $display("FAIL fault_clear: got %b want 00", {fault, busy}); end
  endtask

  task automatic test_retry_once;
    logic [23:0] r;
    r = 24'($urandom);
    rsp = r;
    do_reset(1'b1, 1'b0);
    fail_cnt = 1;
    for (int i = 0; i < 2000 && tv_q.size() == 0; i++) @(negedge clock);
    cmp++; if (tv_q.size() == 0) begin mis++; $display("FAIL retry1_timeout: got 0 pulses want 1"); end
    else begin
      cmp++; if (tv_q[0] !== expect_time(r)) begin mis++; $display("FAIL retry1_data: got %h want %h", tv_q[0], expect_time(r)); end
      cmp++; if (tv_tx[0] !== 2) begin mis++; $display("FAIL retry1_attempts: got %0d want 2", tv_tx[0]); end
    end
    cmp++; if (fault !== 1'b0) begin mis++; $display("FAIL retry1_fault: got %b want 0", fault); end
    // Two more failures only reach the limit if the earlier one was not forgotten.
    fail_cnt = 2;
    repeat (3000) @(negedge clock);
    cmp++; if (fault !== 1'b0) begin mis++; $display("FAIL retry_count_reset: got fault %b want 0", fault); end
  endtask

  task automatic test_reset_midjob;
    bit seen;
    seen = 1'b0;
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (busy && !i2cReady && !i2cStart) begin seen = 1'b1; break; end
    end
    cmp++; if (!seen) begin mis++; $display("FAIL midjob_reach: got 0 want 1"); end
    reset = 1'b0;
    #1;
    cmp++; if ({i2cStart, busy, timeValid} !== 3'b000) begin
      mis++; $display("FAIL midjob_async: got %b want 000", {i2cStart, busy, timeValid}); end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    cmp++; if ({busy, setTimeReady} !== 2'b01) begin mis++; $display("FAIL midjob_idle: got %b want 01", {busy, setTimeReady}); end
  endtask

  task automatic test_ready_low;
    int bad;
    bit started;
    bad = 0; started = 1'b0;
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 100 && !busy; i++) @(negedge clock);
    cmp++; if (busy !== 1'b1) begin mis++; $display("FAIL rdylow_busy: got %b want 1", busy); end
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (i2cStart !== 1'b0) bad++;
    end
    cmp++; if (bad != 0) begin mis++; $display("FAIL rdylow_start: got %0d cycles high want 0", bad); end
    hold_low = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i2cStart || tx_count > 0) begin started = 1'b1; break; end
    end
    cmp++; if (!started) begin mis++; $display("FAIL rdylow_release: got no start want start"); end
  endtask

  task automatic test_random;
    bit ok;
    int n;
    logic [23:0] d;
    rsp = '0;
    do_reset(1'b1, 1'b0);
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        d = {to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)), to_bcd($urandom_range(0, 59))};
        send_set(d, ok);
        n = tx_count;
        for (int i = 0; i < 50 && tx_count <= n; i++) @(negedge clock);
        cmp++; if (!ok || tx_count <= n) begin mis++; $display("FAIL rnd_set_issue: it %0d got none want one", it); end
        else if ({tx_ns[n], tx_bytes[n], tx_nr[n]} !== {3'd4, d, 8'h00, 3'd0}) begin
          mis++; $display("FAIL rnd_set_desc: it %0d got %0d/%h want 4/%h", it, tx_ns[n], tx_bytes[n], {d, 8'h00}); end
      end else begin
        rsp = 24'($urandom);
        n = tv_q.size();
        for (int i = 0; i < 200 && tv_q.size() < n + 2; i++) @(negedge clock);
        cmp++; if (tv_q.size() < n + 2) begin mis++; $display("FAIL rnd_poll_timeout: it %0d", it); end
        else if (tv_q[n+1] !== expect_time(rsp)) begin
          mis++; $display("FAIL rnd_poll_data: it %0d got %h want %h", it, tv_q[n+1], expect_time(rsp)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_poll();
    test_set_vs_poll();
    test_retry_fault();
    test_retry_once();
    test_reset_midjob();
    test_ready_low();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
